// File: rtl/avr_cpu_return_stack.sv
// LIFO return-address stack for the AVR core.
// CALL/IRQ push and RET/RETI pop over one shared tristate bus.
module avr_cpu_return_stack #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire [WIDTH-1:0] data,
  input  logic          write,
  input  logic          read,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_dec;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] top_q;
  logic             drive;

  assign sp_dec  = sp - 1'b1;
  assign top_idx = sp_dec[IW-1:0];
  assign wr_idx  = sp[IW-1:0];

  assign empty = (sp == '0);
  assign full  = (sp == CW'(DEPTH));
  assign count = sp;

  // An empty pop reads back zero rather than stale storage.
  assign top_q = empty ? '0 : mem[top_idx];
  assign drive = read && !write && !rst;
  assign data  = drive ? top_q : {WIDTH{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case ({write, read})
        2'b10: begin
          if (!full) begin
            mem[wr_idx] <= data;
            sp          <= sp + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        2'b01: begin
          if (!empty) begin
            sp <= sp_dec;
          end else begin
            underflow <= 1'b1;
          end
        end
        2'b11: begin
          // Pop-then-push folds into replacing the top entry.
          if (empty) begin
            mem[0] <= data;
            sp     <= sp + 1'b1;
          end else begin
            mem[top_idx] <= data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avr_cpu_return_stack.sv
// Directed vector bench for avr_cpu_return_stack.
// The bench drives the bus whenever the stack should not, exposing stray drive.
module tb_avr_cpu_return_stack;

  logic       clk;
  logic       rst;
  logic       write;
  logic       read;
  logic [8:0] tb_data;
  logic       tb_drv;
  wire  [8:0] data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks;
  int errors;

  assign data = tb_drv ? tb_data : 9'bz;

  avr_cpu_return_stack #(
    .WIDTH(9),
    .DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .write    (write),
    .read     (read),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [8:0] din;
    logic [8:0] bus;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic rd, logic [8:0] din,
                              logic [8:0] bus, logic [3:0] cnt,
                              logic emp, logic ful,
                              logic ovf, logic unf);
    vec_t v;
    v.wr  = wr;
    v.rd  = rd;
    v.din = din;
    v.bus = bus;
    v.cnt = cnt;
    v.emp = emp;
    v.ful = ful;
    v.ovf = ovf;
    v.unf = unf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(string tag, logic [3:0] cnt, logic emp,
                           logic ful, logic ovf, logic unf);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".empty"}, 32'(empty), 32'(emp));
    chk({tag, ".full"}, 32'(full), 32'(ful));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(unf));
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic apply(vec_t v, string tag);
    write   = v.wr;
    read    = v.rd;
    tb_data = v.din;
    tb_drv  = !(v.rd && !v.wr);
    #3;
    chk({tag, ".bus"}, 32'(data), 32'(v.bus));
    @(posedge clk);
    #1;
    chk_state(tag, v.cnt, v.emp, v.ful, v.ovf, v.unf);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    write   = 1'b0;
    read    = 1'b0;
    tb_data = 9'h000;
    tb_drv  = 1'b1;
    #12;
    chk_state("reset", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // push 1..4, pop back 4..1
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk(1, 0, 9'(k), 9'(k), 4'(k), 0, 0, 0, 0));
    for (int k = 4; k >= 1; k--)
      vecs.push_back(mk(0, 1, 9'h000, 9'(k), 4'(k - 1), k == 1, 0, 0, 0));
    // pop on empty
    vecs.push_back(mk(0, 1, 9'h000, 9'h000, 4'd0, 1, 0, 0, 1));
    // push 5, replace with 7, pop 7
    vecs.push_back(mk(1, 0, 9'd5, 9'd5, 4'd1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 9'd7, 9'd7, 4'd1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 9'h000, 9'd7, 4'd0, 1, 0, 0, 1));
    // idle: stale entry 7 must not appear
    vecs.push_back(mk(0, 0, 9'h000, 9'h000, 4'd0, 1, 0, 0, 1));
    // fill with 10..17, push 99 while full
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 0, 9'(10 + k), 9'(10 + k), 4'(k + 1),
                        0, k == 7, 0, 1));
    vecs.push_back(mk(1, 0, 9'd99, 9'd99, 4'd8, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 9'h000, 9'd17, 4'd7, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 9'h000, 9'h000, 4'd7, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 9'h100, 9'h100, 4'd7, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 9'h000, 9'h100, 4'd6, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 9'h000, 9'd15, 4'd5, 0, 0, 1, 1));
    // three fresh pushes before the mid-cycle reset
    vecs.push_back(mk(1, 0, 9'h1A1, 9'h1A1, 4'd6, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 9'h1A2, 9'h1A2, 4'd7, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 9'h1A3, 9'h1A3, 4'd8, 0, 1, 1, 1));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("v%0d", i));

    // async reset between edges clears everything immediately
    write   = 1'b0;
    read    = 1'b0;
    tb_data = 9'h000;
    tb_drv  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply(mk(0, 1, 9'h000, 9'h000, 4'd0, 1, 0, 0, 1), "post_rst_pop");
    apply(mk(1, 0, 9'h0C3, 9'h0C3, 4'd1, 0, 0, 0, 1), "post_rst_push");
    apply(mk(0, 1, 9'h000, 9'h0C3, 4'd0, 1, 0, 0, 1), "post_rst_pop2");

    // reset held across an edge while popping: request ignored
    write  = 1'b0;
    read   = 1'b1;
    tb_drv = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    chk_state("rst_hold", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    read = 1'b0;
    rst  = 1'b0;
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
